spi_txn_arbiter: RTL
====================

// Module: spi_txn_arbiter
// PURPOSE
//  Two-requester, round-robin transaction scheduler in front of one spi_module instance.
//  Each requester (0: sensor config sequencer, 1: host/UART bridge) posts a single write or read.
//  The arbiter sequences the SPI engine's SDO/SDI handshakes and returns one response per grant.
//  It also enforces an idle gap and a watchdog timeout per transaction.
// PARAMETERS
//  DATA_WIDTH      32    word width; must match the attached spi_module.
//  GAP_CYCLES      4     idle clocks after each transaction, so the engine settles in IDLE (min 2).
//  TIMEOUT_CYCLES  256   maximum clocks spent waiting on the engine per transaction.
// PORTS
//  clk_i              in   1           system clock; same clock as spi_module.
//  rst_n              in   1           asynchronous, active-low reset.
//  reqN_valid_i       in   1           N=0,1: request pending; hold high until reqN_ready_o.
//  reqN_rd_i          in   1           1 = read, 0 = write.
//  reqN_data_i        in   DATA_WIDTH  write word (ignored for reads).
//  reqN_ready_o       out  1           one-cycle accept pulse (request consumed).
//  rsp_valid_o        out  1           one-cycle response pulse.
//  rsp_id_o           out  1           requester that owns the response.
//  rsp_data_o         out  DATA_WIDTH  read data; 0 for writes and on error.
//  rsp_err_o          out  1           transaction timed out.
//  spi_sdo_data_o     out  DATA_WIDTH  to spi_module sdo_data_i.
//  spi_sdo_valid_o    out  1           to spi_module sdo_valid_i.
//  spi_sdo_ready_i    in   1           from spi_module sdo_ready_o (high while shifting).
//  spi_sdi_ready_o    out  1           to spi_module sdi_ready_i.
//  spi_sdi_valid_i    in   1           from spi_module sdi_valid_o (pulse on last bit).
//  spi_sdi_data_i     in   DATA_WIDTH  from spi_module sdi_data_o.
//  busy_o             out  1           high in every state except IDLE.
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; round-robin pointer = 0 (requester 0 has priority first).
//  Outputs are registered. Reset mid-transaction aborts it with no response.
//  FSM states:
//   IDLE  -> ARB when any reqN_valid_i is high.
//   ARB   one cycle. Grant goes to the pointer's requester if it is valid, else to the other.
//         Pulse reqN_ready_o; latch rd/data/id; flip the pointer to the non-granted requester.
//         Next state is W_REQ (write) or R_REQ (read).
//   W_REQ spi_sdo_data_o = latched word; spi_sdo_valid_o = 1 for exactly one cycle -> W_START.
//   W_START wait for spi_sdo_ready_i = 1 -> W_END.
//   W_END wait for spi_sdo_ready_i = 0 -> RESP (write done).
//   R_REQ spi_sdi_ready_o = 1 for exactly one cycle -> R_WAIT.
//   R_WAIT wait for spi_sdi_valid_i = 1. Capture spi_sdi_data_i in that same cycle -> RESP.
//   RESP  one cycle: rsp_valid_o = 1 with id/data/err -> GAP.
//   GAP   hold GAP_CYCLES clocks with spi_* strobes low -> IDLE.
//  Timeout:
//   - A counter clears on entry to W_START/R_WAIT and runs through W_START, W_END and R_WAIT.
//   - When it reaches TIMEOUT_CYCLES-1 without the awaited event -> RESP with rsp_err_o = 1
//     and rsp_data_o = 0.
//  Simultaneous events:
//   - Both requesters valid: the pointer decides, so back-to-back traffic alternates 0,1,0,1.
//   - A request arriving during a transaction waits; it is never dropped.
//   - The awaited event on the timeout cycle counts as success (event beats timeout).
//  spi_sdo_data_o holds the latched word from W_REQ until the next ARB.
//  spi_sdo_valid_o and spi_sdi_ready_o are never high together.
//  Throughput: at most 1 transaction per (3 + engine time + GAP_CYCLES) clocks.
// TESTING
//  1 Write: req0 wr 0xA5A5_0001, engine model holds sdo_ready 32 clk -> req0_ready pulse,
//    sdo_valid 1 clk, then rsp_valid id=0 err=0 data=0.
//  2 Read: req1 rd, model pulses sdi_valid with 0x1234_5678 -> rsp id=1 data=0x1234_5678.
//  3 Contention: req0 and req1 held valid for 4 txns -> grants 0,1,0,1, each separated by
//    >= GAP_CYCLES idle clocks.
//  4 Timeout: read where sdi_valid never arrives -> rsp_err=1, data=0
//    TIMEOUT_CYCLES clk after R_WAIT entry; then IDLE.
//  5 Reset asserted in W_END -> all outputs 0 immediately; no rsp;
//    next request is served starting with requester 0.
//  6 End-to-end with the real spi_module in loopback (mosi->miso): write then read
//    -> sck activity only in the engine's data phases; rsp counts match grants.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// Two-requester round-robin transaction scheduler in front of a single SPI engine.
// Latency: accept pulse 2 clk after valid from IDLE; response 1 clk after the engine event.
// Backpressure: requests wait until accepted; engine waits are bounded by a watchdog.
//
// Ports:
//   clk_i, rst_n                      clock, asynchronous active-low reset
//   reqN_valid_i/rd_i/data_i          requester N posts a read (rd=1) or write word
//   reqN_ready_o                      one-cycle accept pulse
//   rsp_valid_o/id_o/data_o/err_o     one-cycle response; data is 0 for writes and on error
//   spi_sdo_* / spi_sdi_*             handshakes with the attached spi_module
//   busy_o                            high whenever the scheduler is not idle
module spi_txn_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  req0_valid_i,
  input  logic                  req0_rd_i,
  input  logic [DATA_WIDTH-1:0] req0_data_i,
  output logic                  req0_ready_o,
  input  logic                  req1_valid_i,
  input  logic                  req1_rd_i,
  input  logic [DATA_WIDTH-1:0] req1_data_i,
  output logic                  req1_ready_o,
  output logic                  rsp_valid_o,
  output logic                  rsp_id_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o,
  output logic [DATA_WIDTH-1:0] spi_sdo_data_o,
  output logic                  spi_sdo_valid_o,
  input  logic                  spi_sdo_ready_i,
  output logic                  spi_sdi_ready_o,
  input  logic                  spi_sdi_valid_i,
  input  logic [DATA_WIDTH-1:0] spi_sdi_data_i,
  output logic                  busy_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, ARB, W_REQ, W_START, W_END, R_REQ, R_WAIT, RESP, GAP
  } state_t;

  state_t          state;
  logic            ptr;      // requester that wins the next tie
  logic            cur_id;
  logic [TW-1:0]   tcnt;
  logic [GW-1:0]   gcnt;

  logic                  grant_vld;
  logic                  grant_id;
  logic                  grant_rd;
  logic [DATA_WIDTH-1:0] grant_data;

  // Pointer's requester wins if it is asking, otherwise the other one.
  always_comb begin
    grant_vld  = req0_valid_i | req1_valid_i;
    grant_id   = ptr ? req1_valid_i : ~req0_valid_i;
    grant_rd   = grant_id ? req1_rd_i   : req0_rd_i;
    grant_data = grant_id ? req1_data_i : req0_data_i;
  end

  // Each strobe is registered on entry to the state it belongs to, so
  // sdo_valid is visible during W_REQ, sdi_ready during R_REQ and
  // rsp_valid during RESP. The watchdog counter keeps running from
  // W_START into W_END so one budget covers the whole write.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ptr             <= 1'b0;
      cur_id          <= 1'b0;
      tcnt            <= '0;
      gcnt            <= '0;
      req0_ready_o    <= 1'b0;
      req1_ready_o    <= 1'b0;
      rsp_valid_o     <= 1'b0;
      rsp_id_o        <= 1'b0;
      rsp_data_o      <= '0;
      rsp_err_o       <= 1'b0;
      spi_sdo_data_o  <= '0;
      spi_sdo_valid_o <= 1'b0;
      spi_sdi_ready_o <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      req0_ready_o    <= 1'b0;
      req1_ready_o    <= 1'b0;
      rsp_valid_o     <= 1'b0;
      spi_sdo_valid_o <= 1'b0;
      spi_sdi_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            state  <= ARB;
            busy_o <= 1'b1;
          end
        end
        ARB: begin
          if (grant_vld) begin
            cur_id       <= grant_id;
            ptr          <= ~grant_id;
            req0_ready_o <= ~grant_id;
            req1_ready_o <= grant_id;
            if (grant_rd) begin
              spi_sdi_ready_o <= 1'b1;
              state           <= R_REQ;
            end else begin
              spi_sdo_data_o  <= grant_data;
              spi_sdo_valid_o <= 1'b1;
              state           <= W_REQ;
            end
          end else begin
            // Request withdrawn before the grant: nothing to serve.
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        W_REQ: begin
          tcnt  <= '0;
          state <= W_START;
        end
        W_START: begin
          if (spi_sdo_ready_i) begin
            tcnt  <= tcnt + TW'(1);
            state <= W_END;
          end else if (tcnt == T_LAST) begin
            rsp_valid_o <= 1'b1;
            rsp_id_o    <= cur_id;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b1;
            state       <= RESP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        W_END: begin
          // Event is tested before the watchdog so it wins on the last cycle.
          if (!spi_sdo_ready_i || tcnt == T_LAST) begin
            rsp_valid_o <= 1'b1;
            rsp_id_o    <= cur_id;
            rsp_data_o  <= '0;
            rsp_err_o   <= spi_sdo_ready_i;
            state       <= RESP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        R_REQ: begin
          tcnt  <= '0;
          state <= R_WAIT;
        end
        R_WAIT: begin
          if (spi_sdi_valid_i || tcnt == T_LAST) begin
            rsp_valid_o <= 1'b1;
            rsp_id_o    <= cur_id;
            rsp_data_o  <= spi_sdi_valid_i ? spi_sdi_data_i : '0;
            rsp_err_o   <= ~spi_sdi_valid_i;
            state       <= RESP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        RESP: begin
          gcnt  <= '0;
          state <= GAP;
        end
        GAP: begin
          if (gcnt == G_LAST) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
